// File: rtl/quick_spi_cmd_sequencer.sv
// Command front-end for quick_spi_hard: buffers SPI commands in a small FIFO,
// issues them one at a time to the master, waits for end-of-transaction with a
// timeout, and returns read data on a valid/ready response port.
module quick_spi_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned SLAVES_WIDTH   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SLAVES_WIDTH-1:0] cmd_slave,
    input  logic                    cmd_read,
    input  logic [OUT_WIDTH-1:0]    cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IN_WIDTH-1:0]     rsp_data,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    spi_enable,
    output logic                    spi_start_transaction,
    output logic                    spi_operation,
    output logic [SLAVES_WIDTH-1:0] spi_slave,
    output logic [OUT_WIDTH-1:0]    spi_outgoing_data,
    input  logic                    spi_end_of_transaction,
    input  logic [IN_WIDTH-1:0]     spi_incoming_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [SLAVES_WIDTH-1:0] fifo_slave [FIFO_DEPTH];
    logic                    fifo_read  [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]    fifo_data  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [TO_W-1:0]         wait_cnt;

    logic push, pop, eot_hit, to_hit;

    // Handshake decodes, FSM next state and combinational outputs
    always_comb begin
        state_next            = state;
        cmd_ready             = (count != CNT_W'(FIFO_DEPTH));
        push                  = cmd_valid && cmd_ready;
        pop                   = (state == IDLE) && (count != '0);
        eot_hit               = (state == WAIT) && spi_end_of_transaction;
        to_hit                = (state == WAIT) && !spi_end_of_transaction &&
                                (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        spi_start_transaction = (state == START);
        busy                  = (count != '0) || (state != IDLE);
        case (state)
            IDLE:    if (pop) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (eot_hit)     state_next = spi_operation ? RESP : IDLE;
                else if (to_hit) state_next = IDLE;
            end
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_slave[wr_ptr] <= cmd_slave;
            fifo_read[wr_ptr]  <= cmd_read;
            fifo_data[wr_ptr]  <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Master-facing command registers, loaded only when the FIFO head is popped
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_slave         <= '0;
            spi_operation     <= 1'b0;
            spi_outgoing_data <= '0;
        end else if (pop) begin
            spi_slave         <= fifo_slave[rd_ptr];
            spi_operation     <= fifo_read[rd_ptr];
            spi_outgoing_data <= fifo_data[rd_ptr];
        end
    end

    // WAIT-cycle counter, cleared outside WAIT and on eot or timeout
    always_ff @(posedge clk) begin
        if (reset)                           wait_cnt <= '0;
        else if (state == WAIT && !eot_hit && !to_hit) wait_cnt <= wait_cnt + 1'b1;
        else                                 wait_cnt <= '0;
    end

    // Read response capture and handshake, sticky timeout flag, master enable
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            timeout_err <= 1'b0;
            spi_enable  <= 1'b0;
        end else begin
            spi_enable <= 1'b1;
            if (eot_hit && spi_operation) begin
                rsp_valid <= 1'b1;
                rsp_data  <= spi_incoming_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (to_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quick_spi_cmd_sequencer.sv
// Self-checking bench for quick_spi_cmd_sequencer. The main instance uses the
// default timeout; a second instance with a 16-cycle timeout covers abort paths.
module tb_quick_spi_cmd_sequencer;

    typedef struct packed {
        logic [1:0]  slave;
        logic        read;
        logic [15:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [1:0]  cmd_slave;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        busy, timeout_err, spi_enable, spi_start, spi_op;
    logic [1:0]  spi_slave;
    logic [15:0] spi_out;
    logic        eot;
    logic [7:0]  inc;

    logic        t_cmd_valid, t_cmd_ready, t_cmd_read;
    logic [1:0]  t_cmd_slave;
    logic [15:0] t_cmd_data;
    logic        t_rsp_valid, t_rsp_ready;
    logic [7:0]  t_rsp_data;
    logic        t_busy, t_timeout_err, t_spi_enable, t_spi_start, t_spi_op;
    logic [1:0]  t_spi_slave;
    logic [15:0] t_spi_out;
    logic        t_eot;
    logic [7:0]  t_inc;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];
    logic [7:0] rsp_q[$];

    always #5 clk = ~clk;

    quick_spi_cmd_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave),
        .cmd_read(cmd_read), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .timeout_err(timeout_err), .spi_enable(spi_enable),
        .spi_start_transaction(spi_start), .spi_operation(spi_op),
        .spi_slave(spi_slave), .spi_outgoing_data(spi_out),
        .spi_end_of_transaction(eot), .spi_incoming_data(inc)
    );

    quick_spi_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset(reset),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_slave(t_cmd_slave),
        .cmd_read(t_cmd_read), .cmd_data(t_cmd_data),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
        .busy(t_busy), .timeout_err(t_timeout_err), .spi_enable(t_spi_enable),
        .spi_start_transaction(t_spi_start), .spi_operation(t_spi_op),
        .spi_slave(t_spi_slave), .spi_outgoing_data(t_spi_out),
        .spi_end_of_transaction(t_eot), .spi_incoming_data(t_inc)
    );

    // One clock on the main instance; an accepted command joins the expected queue
    task automatic tick();
        logic acc;
        acc = cmd_valid && cmd_ready;
        @(posedge clk); #1;
        if (acc) begin
            exp_q.push_back({cmd_slave, cmd_read, cmd_data});
            cmd_valid = 1'b0;
        end
    endtask

    task automatic ttick();
        @(posedge clk); #1;
    endtask

    task automatic drive_idle();
        cmd_valid = 0; cmd_slave = 0; cmd_read = 0; cmd_data = 0; rsp_ready = 0; eot = 0; inc = 0;
        t_cmd_valid = 0; t_cmd_slave = 0; t_cmd_read = 0; t_cmd_data = 0; t_rsp_ready = 0; t_eot = 0; t_inc = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) ttick();
        reset = 1'b0;
        exp_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) ttick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, busy, timeout_err, spi_enable, spi_start, spi_op, spi_slave, spi_out}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b rv=%b rd=%h busy=%b to=%b en=%b st=%b op=%b sl=%h out=%h want ready=1 rest 0",
                     cmd_ready, rsp_valid, rsp_data, busy, timeout_err, spi_enable, spi_start, spi_op, spi_slave, spi_out);
        end
        reset = 1'b0;
        exp_q.delete();
        ttick();
        checks++;
        if (spi_enable !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL enable_after_reset got en=%b ready=%b want 1 1", spi_enable, cmd_ready);
        end
    endtask

    task automatic test_write();
        int pulses = 0;
        bit seen_rsp = 0;
        do_reset();
        cmd_valid = 1; cmd_slave = 2'd1; cmd_read = 0; cmd_data = 16'hCC82;
        tick();
        checks++;
        if (busy !== 1'b1 || spi_start !== 1'b0) begin
            errors++; $display("FAIL write_pushed got busy=%b start=%b want 1 0", busy, spi_start);
        end
        tick();
        checks++;
        if ({spi_start, spi_slave, spi_op, spi_out} !== {1'b1, 2'd1, 1'b0, 16'hCC82}) begin
            errors++; $display("FAIL write_start got st=%b sl=%h op=%b out=%h want 1 1 0 cc82", spi_start, spi_slave, spi_op, spi_out);
        end
        repeat (39) begin
            tick();
            if (spi_start) pulses++;
            if (rsp_valid) seen_rsp = 1;
        end
        eot = 1; inc = 8'hA5;
        tick();
        eot = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_fall got %b want 0", busy); end
        repeat (5) begin
            tick();
            if (spi_start) pulses++;
            if (rsp_valid) seen_rsp = 1;
        end
        checks++;
        if (pulses != 0 || seen_rsp) begin
            errors++; $display("FAIL write_single_pulse_no_rsp got extra_pulses=%0d rsp=%b want 0 0", pulses, seen_rsp);
        end
        checks++;
        if (spi_out !== 16'hCC82 || spi_op !== 1'b0) begin
            errors++; $display("FAIL write_hold got out=%h op=%b want cc82 0", spi_out, spi_op);
        end
    endtask

    task automatic test_read();
        bit stable = 1;
        do_reset();
        cmd_valid = 1; cmd_slave = 2'd1; cmd_read = 1; cmd_data = 16'h0000;
        tick();
        tick();
        checks++;
        if (spi_start !== 1'b1 || spi_op !== 1'b1) begin
            errors++; $display("FAIL read_start got st=%b op=%b want 1 1", spi_start, spi_op);
        end
        repeat (6) tick();
        inc = 8'h95; eot = 1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_early got %b want 0", rsp_valid); end
        tick();
        eot = 0; inc = 8'h3A;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h95) begin
            errors++; $display("FAIL read_rsp got v=%b d=%h want 1 95", rsp_valid, rsp_data);
        end
        repeat (5) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h95) stable = 0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL read_rsp_hold got v=%b d=%h want 1 95", rsp_valid, rsp_data); end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL read_rsp_clear got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_full_order();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d got 0 want 1", k); end
            cmd_valid = 1; cmd_slave = 2'(k % 4); cmd_read = 0; cmd_data = 16'(k);
            tick();
            if (k == 2) begin
                checks++;
                if (spi_start !== 1'b1 || spi_out !== 16'd1) begin
                    errors++; $display("FAIL full_first_start got st=%b out=%h want 1 0001", spi_start, spi_out);
                end
            end
        end
        // one command in flight plus four buffered
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_ready_low got ready=%b busy=%b want 0 1", cmd_ready, busy);
        end
        cmd_valid = 1; cmd_slave = 2'd2; cmd_read = 0; cmd_data = 16'd6;
        for (int served = 1; served <= 6; served++) begin
            repeat (3) tick();
            eot = 1;
            tick();
            eot = 0;
            checks++;
            if (spi_start !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got start=1 want 0", served); end
            if (served == 1) begin
                checks++;
                if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got ready=1 want 0"); end
            end
            if (served < 6) begin
                tick();
                checks++;
                if ({spi_start, spi_slave, spi_out} !== {1'b1, 2'((served + 1) % 4), 16'(served + 1)}) begin
                    errors++; $display("FAIL order_start%0d got st=%b sl=%h out=%h want 1 %h %h",
                                       served + 1, spi_start, spi_slave, spi_out, 2'((served + 1) % 4), 16'(served + 1));
                end
                if (served == 1) begin
                    checks++;
                    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got 0 want 1"); end
                    tick();
                    checks++;
                    if (cmd_ready !== 1'b0 || cmd_valid !== 1'b0) begin
                        errors++; $display("FAIL full_refill got ready=%b pending=%b want 0 0", cmd_ready, cmd_valid);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy got 1 want 0"); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        bit seen_rsp = 0;
        do_reset();
        // eot in the last permitted WAIT cycle still completes normally
        t_cmd_valid = 1; t_cmd_slave = 2'd2; t_cmd_read = 1; t_cmd_data = 16'h1234;
        ttick();
        t_cmd_valid = 0;
        ttick();
        checks++;
        if (t_spi_start !== 1'b1) begin errors++; $display("FAIL to_boundary_start got 0 want 1"); end
        repeat (16) ttick();
        d = 8'($urandom); t_inc = d; t_eot = 1;
        ttick();
        t_eot = 0;
        checks++;
        if (t_rsp_valid !== 1'b1 || t_rsp_data !== d || t_timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_boundary_eot got v=%b d=%h err=%b want 1 %h 0", t_rsp_valid, t_rsp_data, t_timeout_err, d);
        end
        t_rsp_ready = 1;
        ttick();
        t_rsp_ready = 0;
        t_cmd_valid = 1; t_cmd_slave = 2'd3; t_cmd_read = 0; t_cmd_data = 16'hAAAA;
        ttick();
        t_cmd_slave = 2'd0; t_cmd_read = 1; t_cmd_data = 16'hBBBB;
        ttick();
        t_cmd_valid = 0;
        checks++;
        if (t_spi_start !== 1'b1 || t_spi_out !== 16'hAAAA) begin
            errors++; $display("FAIL to_start_a got st=%b out=%h want 1 aaaa", t_spi_start, t_spi_out);
        end
        repeat (16) ttick();
        checks++;
        if (t_timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got err=1 want 0"); end
        ttick();
        checks++;
        if (t_timeout_err !== 1'b1 || t_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL to_fire got err=%b rv=%b want 1 0", t_timeout_err, t_rsp_valid);
        end
        ttick();
        checks++;
        if ({t_spi_start, t_spi_op, t_spi_out} !== {1'b1, 1'b1, 16'hBBBB}) begin
            errors++; $display("FAIL to_next_issued got st=%b op=%b out=%h want 1 1 bbbb", t_spi_start, t_spi_op, t_spi_out);
        end
        repeat (20) begin
            ttick();
            if (t_rsp_valid) seen_rsp = 1;
        end
        checks++;
        if (t_timeout_err !== 1'b1 || seen_rsp || t_busy !== 1'b0) begin
            errors++; $display("FAIL to_sticky got err=%b rsp=%b busy=%b want 1 0 0", t_timeout_err, seen_rsp, t_busy);
        end
    endtask

    task automatic test_midop_reset();
        bit bad = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1; cmd_slave = 2'd2; cmd_read = 1; cmd_data = 16'(16'h11 + k);
            tick();
        end
        tick();
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midop_pre got busy=%b ready=%b want 1 1", busy, cmd_ready);
        end
        reset = 1;
        repeat (2) tick();
        reset = 0;
        exp_q.delete();
        checks++;
        if ({busy, cmd_ready, rsp_valid, spi_start, spi_op, spi_slave, spi_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            errors++; $display("FAIL midop_cleared got busy=%b ready=%b rv=%b st=%b op=%b sl=%h out=%h want 0 1 0 0 0 0 0",
                               busy, cmd_ready, rsp_valid, spi_start, spi_op, spi_slave, spi_out);
        end
        eot = 1; inc = 8'h77;
        repeat (3) begin
            tick();
            if (rsp_valid || spi_start || busy) bad = 1;
        end
        eot = 0;
        repeat (5) begin
            tick();
            if (rsp_valid || spi_start || busy) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midop_late_eot got activity=1 want 0"); end
    endtask

    task automatic test_random();
        localparam int N = 30;
        int   pushed = 0, starts = 0, timer = 0;
        bit   done = 0, cur_read = 0;
        cmd_t c;
        do_reset();
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (spi_start) begin
                starts++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_start_unexpected got start with empty model want none");
                end else begin
                    c = exp_q.pop_front();
                    cur_read = c.read;
                    if ({spi_slave, spi_op, spi_out} !== c) begin
                        errors++; $display("FAIL rand_start got sl=%h op=%b out=%h want %h %b %h",
                                           spi_slave, spi_op, spi_out, c.slave, c.read, c.data);
                    end
                end
                timer = $urandom_range(20, 2);
            end
            eot = 0;
            if (timer == 1) begin
                eot = 1;
                inc = 8'($urandom);
                if (cur_read) rsp_q.push_back(inc);
            end
            if (timer > 0) timer--;
            rsp_ready = 1'($urandom);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++; $display("FAIL rand_rsp_unexpected got d=%h want no response", rsp_data);
                end else begin
                    logic [7:0] e;
                    e = rsp_q.pop_front();
                    if (rsp_data !== e) begin errors++; $display("FAIL rand_rsp got %h want %h", rsp_data, e); end
                end
            end
            if (!cmd_valid && pushed < N && ($urandom % 3) == 0) begin
                cmd_valid = 1; cmd_slave = 2'($urandom); cmd_read = 1'($urandom); cmd_data = 16'($urandom);
                pushed++;
            end
            tick();
            done = (pushed == N) && !cmd_valid && !busy && !rsp_valid && timer == 0;
        end
        eot = 0; rsp_ready = 0;
        checks++;
        if (!done || starts != N || exp_q.size() != 0 || rsp_q.size() != 0) begin
            errors++; $display("FAIL rand_complete got done=%b starts=%0d left=%0d rsp_left=%0d want 1 %0d 0 0",
                               done, starts, exp_q.size(), rsp_q.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full_order();
        test_timeout();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1);
    end

endmodule
